// File: rtl/ps2_pkg.sv
// PS/2 receive definitions shared with the keyboard matrix decoder.
`timescale 1ns/1ps
package ps2_pkg;

  // Receiver frame position
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Scan-code prefixes consumed by the matrix decoder
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Start + 8 data + parity + stop
  localparam int unsigned PS2_FRAME_LEN = 11;

  // Odd parity: the byte plus its parity bit must hold an odd number of ones
  function automatic logic ps2_odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter for one raw PS/2 pin.
// The filtered line only changes after FILTER_LEN consecutive synced samples
// disagree with it; both the synchronizer and the filtered line reset to 1
// (idle level of the open-collector bus).
`timescale 1ns/1ps
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_line
);

  localparam int unsigned      CW      = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(FILTER_LEN - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_line;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has been stable for FILTER_LEN samples
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_line <= 1'b1;
      r_cnt  <= '0;
    end else if (r_sync2 == r_line) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_line <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver (receive only, never drives the bus).
// Delivers one byte per good frame with a single-cycle data_rdy strobe;
// bad stop bits and mid-frame clock timeouts pulse frame_err.
// Optional macro PS2_RX_PARITY_CHECK_EN: when defined, odd-parity failures
// pulse parity_err and the byte is dropped; otherwise parity is ignored and
// parity_err is tied low.
`timescale 1ns/1ps
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       data_rdy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned   TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  logic          w_clk_f;
  logic          w_data_f;
  logic          w_timeout;

  logic          r_clk_prev;
  logic          r_edge;
  logic          r_edge_bit;
  ps2_state_e    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shreg;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_data;
  logic          r_rdy;
  logic          r_ferr;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic          r_par;
  logic          r_perr;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_pin   (ps2_clk),
    .o_line  (w_clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_pin   (ps2_data),
    .o_line  (w_data_f)
  );

  // Register the filtered ps2_clk falling edge together with the data level at that moment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_prev <= 1'b1;
      r_edge     <= 1'b0;
      r_edge_bit <= 1'b1;
    end else begin
      r_clk_prev <= w_clk_f;
      r_edge     <= r_clk_prev & ~w_clk_f;
      r_edge_bit <= w_data_f;
    end
  end

  // A pending edge always wins over an expiring timeout
  assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_MAX) && !r_edge;

  // Mid-frame inactivity counter: cleared by edges, idle in IDLE, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (r_edge || (r_state == ST_IDLE)) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Frame sequencing and the registered result strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_rdy     <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      r_par     <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_rdy  <= 1'b0;
      r_ferr <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      r_perr <= 1'b0;
`endif
      if (r_edge) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_edge_bit) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            r_shreg   <= {r_edge_bit, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
            r_par   <= r_edge_bit;
`endif
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (!r_edge_bit) begin
              r_ferr <= 1'b1;
            end
`ifdef PS2_RX_PARITY_CHECK_EN
            else if (!ps2_odd_parity_ok(r_shreg, r_par)) begin
              r_perr <= 1'b1;
            end
`endif
            else begin
              r_data <= r_shreg;
              r_rdy  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (w_timeout) begin
        r_state <= ST_IDLE;
        r_ferr  <= 1'b1;
      end
    end
  end

  assign data      = r_data;
  assign data_rdy  = r_rdy;
  assign frame_err = r_ferr;
  assign busy      = (r_state != ST_IDLE);
`ifdef PS2_RX_PARITY_CHECK_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule
